// File: rtl/bundle_dispatch_sched_pkg.sv
// Shared types and helpers for the bundle dispatch scheduler.
//
// Contents:
//   slot_mask_t   - one bit per bundle slot, bit0 = slot0 (oldest)
//   bundle_ent_t  - buffered bundle: pending slots, jump/call flags, taken-branch flags
//   NSLOTS        - slots per bundle
//   first_n_ones  - keeps the lowest n set bits of a slot mask
//
// `WAYS normally comes from rtfItanium-config.sv. It falls back to 3 here so
// the block also builds stand-alone.

`ifndef WAYS
`define WAYS 3
`endif

package bundle_sched_pkg;

    localparam int NSLOTS = 3;

    typedef logic [NSLOTS-1:0] slot_mask_t;

    typedef struct packed {
        slot_mask_t pend;
        slot_mask_t jc;
        slot_mask_t tb;
    } bundle_ent_t;

    // Scans slot0 -> slot2 and keeps at most n of the set bits, which gives
    // program-order selection of the oldest pending slots.
    function automatic slot_mask_t first_n_ones(slot_mask_t mask, logic [1:0] n);
        slot_mask_t r;
        logic [1:0] c;
        r = '0;
        c = '0;
        for (int i = 0; i < NSLOTS; i++) begin
            if (mask[i] && (c < n)) begin
                r[i] = 1'b1;
                c    = c + 2'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bundle_dispatch_sched_if.sv
// Interface bundling the fetch-side and dispatch-side signals of the bundle
// dispatch scheduler.
//
// Signals:
//   fetch_v, fetch_mask, fetch_jc, fetch_tb - bundle offered by fetch
//   fetch_rdy                                - scheduler can take a bundle
//   canq                                     - free dispatch-queue entries (0..3)
//   branchmiss                               - flush everything
//   debug_on                                 - single-step dispatch
//   issue_mask, issue_last                   - slots issued / head retires this cycle
//   redirect, redirect_slot                  - registered truncation pulse and its slot
//   count                                    - occupied buffer entries
//
// Modports: master drives fetch/control (the environment); slave is the scheduler.

interface bundle_dispatch_sched_if
    import bundle_sched_pkg::*;
#(
    parameter int DEPTH = 4
);
    logic                         fetch_v;
    slot_mask_t                   fetch_mask;
    slot_mask_t                   fetch_jc;
    slot_mask_t                   fetch_tb;
    logic                         fetch_rdy;
    logic [1:0]                   canq;
    logic                         branchmiss;
    logic                         debug_on;
    slot_mask_t                   issue_mask;
    logic                         issue_last;
    logic                         redirect;
    logic [1:0]                   redirect_slot;
    logic [$clog2(DEPTH+1)-1:0]   count;

    modport master (
        output fetch_v, fetch_mask, fetch_jc, fetch_tb, canq, branchmiss, debug_on,
        input  fetch_rdy, issue_mask, issue_last, redirect, redirect_slot, count
    );

    modport slave (
        input  fetch_v, fetch_mask, fetch_jc, fetch_tb, canq, branchmiss, debug_on,
        output fetch_rdy, issue_mask, issue_last, redirect, redirect_slot, count
    );

endinterface

// File: rtl/bundle_dispatch_sched_slot_pick.sv
// slot_pick: combinational slot selection for one bundle.
//
// Ports:
//   pend       in  pending slots of the bundle (0 when nothing may issue)
//   jc, tb     in  per-slot jump/call and predicted-taken branch flags
//   lim        in  max slots to issue this cycle
//   issue_mask out slots issued, oldest first, cut after a control-transfer slot
//   trunc      out an issued slot transfers control
//   trunc_slot out index of the lowest such slot

module slot_pick
    import bundle_sched_pkg::*;
(
    input  slot_mask_t pend,
    input  slot_mask_t jc,
    input  slot_mask_t tb,
    input  logic [1:0] lim,
    output slot_mask_t issue_mask,
    output logic       trunc,
    output logic [1:0] trunc_slot
);

    slot_mask_t sel;
    slot_mask_t brk;

    // Loop runs from slot2 down so the oldest control-transfer slot wins;
    // everything younger than it in the same bundle is dropped.
    always_comb begin
        sel        = first_n_ones(pend, lim);
        brk        = sel & (jc | tb);
        issue_mask = sel;
        trunc      = 1'b0;
        trunc_slot = 2'd0;
        for (int s = NSLOTS - 1; s >= 0; s--) begin
            if (brk[s]) begin
                trunc      = 1'b1;
                trunc_slot = 2'(s);
            end
        end
        if (trunc) begin
            case (trunc_slot)
                2'd0:    issue_mask = sel & 3'b001;
                2'd1:    issue_mask = sel & 3'b011;
                default: issue_mask = sel;
            endcase
        end
    end

endmodule

// File: rtl/bundle_dispatch_sched.sv
// bundle_dispatch_sched: buffers fetched 3-slot bundles and dispatches slots of
// the head bundle in program order, limited by queue space, WAYS and debug
// single-step. Dispatch stops at jumps/predicted-taken branches, which also
// discard all younger bundles and raise a one-cycle redirect.
//
// Ports:
//   clk, rst - clock, asynchronous active-high reset
//   bus      - bundle_dispatch_sched_if.slave (fetch, dispatch, status signals)
//
// Configuration macro DISPATCH_BYPASS_EN: when defined, a bundle arriving at an
// empty buffer dispatches in the same cycle and is stored only if slots remain.

module bundle_dispatch_sched
    import bundle_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WAYS  = `WAYS
) (
    input  logic                  clk,
    input  logic                  rst,
    bundle_dispatch_sched_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    bundle_ent_t    ent [DEPTH];
    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [CW-1:0]  count;
    logic           redirect_q;
    logic [1:0]     redirect_slot_q;

    logic [1:0]     lim;
    logic           byp;
    bundle_ent_t    cur;
    logic           cur_valid;
    slot_mask_t     pend_in;
    slot_mask_t     pick_mask;
    logic           trunc;
    logic [1:0]     trunc_slot;
    slot_mask_t     remain;
    slot_mask_t     push_pend;
    logic           issue_last;
    logic           fetch_rdy;
    logic           push;
    logic           pop;

    // Head selection and push/pop decisions. With bypass, an empty buffer
    // treats the incoming bundle as the head, and only the leftover slots are
    // stored.
    always_comb begin
        if (bus.debug_on)
            lim = 2'd1;
        else if (int'(bus.canq) < WAYS)
            lim = bus.canq;
        else
            lim = 2'(WAYS);

`ifdef DISPATCH_BYPASS_EN
        byp = (count == '0) && bus.fetch_v && !bus.branchmiss && (bus.fetch_mask != '0);
`else
        byp = 1'b0;
`endif

        if (byp)
            cur = '{pend: bus.fetch_mask, jc: bus.fetch_jc, tb: bus.fetch_tb};
        else
            cur = ent[head];
        cur_valid = byp || (count != '0);
        pend_in   = (cur_valid && !bus.branchmiss) ? cur.pend : '0;

        remain     = cur.pend & ~pick_mask;
        issue_last = (pick_mask != '0) && ((remain == '0) || trunc);
        fetch_rdy  = (count < CW'(DEPTH));

        push_pend = byp ? remain : bus.fetch_mask;
        push      = bus.fetch_v && fetch_rdy && !bus.branchmiss && !trunc && (push_pend != '0);
        pop       = issue_last && !byp && !trunc;
    end

    slot_pick u_slot_pick (
        .pend       (pend_in),
        .jc         (cur.jc),
        .tb         (cur.tb),
        .lim        (lim),
        .issue_mask (pick_mask),
        .trunc      (trunc),
        .trunc_slot (trunc_slot)
    );

    // Buffer state. Flush beats truncation, which beats normal pop/push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            redirect_q      <= 1'b0;
            redirect_slot_q <= 2'd0;
            for (int i = 0; i < DEPTH; i++)
                ent[i] <= '0;
        end else begin
            redirect_q <= trunc;
            if (trunc)
                redirect_slot_q <= trunc_slot;

            if (bus.branchmiss) begin
                head  <= tail;
                count <= '0;
                for (int i = 0; i < DEPTH; i++)
                    ent[i].pend <= '0;
            end else if (trunc) begin
                if (!byp) begin
                    head <= head + 1'b1;
                    tail <= head + 1'b1;
                end
                count <= '0;
                for (int i = 0; i < DEPTH; i++)
                    ent[i].pend <= '0;
            end else begin
                if (!byp && (count != '0))
                    ent[head].pend <= remain;
                if (push) begin
                    ent[tail] <= '{pend: push_pend, jc: bus.fetch_jc, tb: bus.fetch_tb};
                    tail      <= tail + 1'b1;
                end
                if (pop)
                    head <= head + 1'b1;
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    assign bus.fetch_rdy     = fetch_rdy;
    assign bus.issue_mask    = pick_mask;
    assign bus.issue_last    = issue_last;
    assign bus.redirect      = redirect_q;
    assign bus.redirect_slot = redirect_slot_q;
    assign bus.count         = count;

    assert property (@(posedge clk) disable iff (rst) !(push && (count == CW'(DEPTH))));
    assert property (@(posedge clk) disable iff (rst) !(pop && (count == '0)));

endmodule

// File: tb/tb_bundle_dispatch_sched.sv
// Testbench for bundle_dispatch_sched. Stimulus pushes expected issue and
// redirect events into queues; a negedge monitor pops and compares whenever
// the DUT presents a non-zero issue_mask or a redirect pulse.

module tb_bundle_dispatch_sched;
    import bundle_sched_pkg::*;

    typedef struct {
        slot_mask_t mask;
        logic       last;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t expQ[$];
    logic [1:0] redQ[$];

    always #5 clk = ~clk;

    bundle_dispatch_sched_if #(.DEPTH(4)) bus ();

    bundle_dispatch_sched #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input slot_mask_t m, input slot_mask_t j,
                                 input slot_mask_t t, input logic [1:0] q, input logic bm,
                                 input logic dbg);
        bus.fetch_v    = v;
        bus.fetch_mask = m;
        bus.fetch_jc   = j;
        bus.fetch_tb   = t;
        bus.canq       = q;
        bus.branchmiss = bm;
        bus.debug_on   = dbg;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    endtask

    // Push with canq=0 so nothing issues in the push cycle in either build.
    task automatic pushBundle(input slot_mask_t m, input slot_mask_t j, input slot_mask_t t);
        applyStimulus(1'b1, m, j, t, 2'd0, 1'b0, 1'b0);
        tick();
        idle();
    endtask

    task automatic dispatchCycle(input logic [1:0] q, input logic dbg);
        applyStimulus(1'b0, 3'b000, 3'b000, 3'b000, q, 1'b0, dbg);
        tick();
        idle();
    endtask

    task automatic expectIssue(input slot_mask_t m, input logic l);
        expQ.push_back('{mask: m, last: l});
    endtask

    // Monitor: compares every presented issue/redirect against the queues.
    initial begin
        exp_t e;
        logic [1:0] rs;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.issue_mask != 3'b000) begin
                    if (expQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_issue: got mask %b last %b expected none at %0t",
                                 bus.issue_mask, bus.issue_last, $time);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("issue_mask", 32'(bus.issue_mask), 32'(e.mask));
                        checkOutput("issue_last", 32'(bus.issue_last), 32'(e.last));
                    end
                end else if (bus.issue_last) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL spurious_last: got issue_last 1 expected 0 at %0t", $time);
                end
                if (bus.redirect) begin
                    if (redQ.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_redirect: got slot %0d expected none at %0t",
                                 bus.redirect_slot, $time);
                    end else begin
                        rs = redQ.pop_front();
                        checkOutput("redirect_slot", 32'(bus.redirect_slot), 32'(rs));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_issue_mask", 32'(bus.issue_mask), 32'h0);
        checkOutput("reset_issue_last", 32'(bus.issue_last), 32'h0);
        checkOutput("reset_fetch_rdy", 32'(bus.fetch_rdy), 32'h1);
        checkOutput("reset_count", 32'(bus.count), 32'h0);
        checkOutput("reset_redirect", 32'(bus.redirect), 32'h0);
        rst = 1'b0;
        tick();

        // Full bundle, full width.
        pushBundle(3'b111, 3'b000, 3'b000);
        checkOutput("t1_count_after_push", 32'(bus.count), 32'd1);
        expectIssue(3'b111, 1'b1);
        dispatchCycle(2'd3, 1'b0);
        checkOutput("t1_count_after_pop", 32'(bus.count), 32'd0);

        // Queue-space limited, then single-step.
        pushBundle(3'b111, 3'b000, 3'b000);
        expectIssue(3'b001, 1'b0);
        dispatchCycle(2'd1, 1'b0);
        checkOutput("t2_count_partial", 32'(bus.count), 32'd1);
        expectIssue(3'b110, 1'b1);
        dispatchCycle(2'd2, 1'b0);
        checkOutput("t2_count_done", 32'(bus.count), 32'd0);
        pushBundle(3'b111, 3'b000, 3'b000);
        expectIssue(3'b001, 1'b0);
        expectIssue(3'b010, 1'b0);
        expectIssue(3'b100, 1'b1);
        for (int i = 0; i < 3; i++)
            dispatchCycle(2'd3, 1'b1);
        checkOutput("t2_count_debug", 32'(bus.count), 32'd0);

        // Predicted-taken branch in slot1 truncates and drops younger work.
        pushBundle(3'b111, 3'b000, 3'b010);
        pushBundle(3'b111, 3'b000, 3'b000);
        checkOutput("t3_count_two", 32'(bus.count), 32'd2);
        expectIssue(3'b011, 1'b1);
        redQ.push_back(2'd1);
        applyStimulus(1'b1, 3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("t3_count_trunc", 32'(bus.count), 32'd0);
        checkOutput("t3_redirect_high", 32'(bus.redirect), 32'd1);
        tick();
        checkOutput("t3_redirect_pulse", 32'(bus.redirect), 32'd0);
        checkOutput("t3_push_dropped", 32'(bus.count), 32'd0);

        // Fill to DEPTH, overflow attempt ignored, one retire reopens.
        for (int i = 0; i < 4; i++)
            pushBundle(3'b111, 3'b000, 3'b000);
        checkOutput("t4_count_full", 32'(bus.count), 32'd4);
        checkOutput("t4_rdy_full", 32'(bus.fetch_rdy), 32'd0);
        applyStimulus(1'b1, 3'b111, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("t4_count_ignored", 32'(bus.count), 32'd4);
        expectIssue(3'b111, 1'b1);
        applyStimulus(1'b1, 3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0);
        #1;
        checkOutput("t4_rdy_same_cycle", 32'(bus.fetch_rdy), 32'd0);
        tick();
        idle();
        checkOutput("t4_count_after_retire", 32'(bus.count), 32'd3);
        checkOutput("t4_rdy_reopen", 32'(bus.fetch_rdy), 32'd1);

        // Branch miss flushes, blocks issue and push.
        applyStimulus(1'b1, 3'b111, 3'b000, 3'b000, 2'd3, 1'b1, 1'b0);
        #1;
        checkOutput("t5_issue_blocked", 32'(bus.issue_mask), 32'd0);
        tick();
        idle();
        checkOutput("t5_count_flush", 32'(bus.count), 32'd0);
        tick();
        checkOutput("t5_no_push", 32'(bus.count), 32'd0);

        // Reset mid-dispatch.
        pushBundle(3'b111, 3'b000, 3'b000);
        pushBundle(3'b111, 3'b000, 3'b000);
        expectIssue(3'b011, 1'b0);
        dispatchCycle(2'd2, 1'b0);
        checkOutput("t6_count_before_rst", 32'(bus.count), 32'd2);
        bus.canq = 2'd3;
        rst = 1'b1;
        #1;
        checkOutput("t6_rst_issue_mask", 32'(bus.issue_mask), 32'd0);
        checkOutput("t6_rst_issue_last", 32'(bus.issue_last), 32'd0);
        checkOutput("t6_rst_count", 32'(bus.count), 32'd0);
        checkOutput("t6_rst_fetch_rdy", 32'(bus.fetch_rdy), 32'd1);
        idle();
        tick();
        rst = 1'b0;
        tick();
        pushBundle(3'b111, 3'b000, 3'b000);
        expectIssue(3'b111, 1'b1);
        dispatchCycle(2'd3, 1'b0);
        checkOutput("t6_count_resume", 32'(bus.count), 32'd0);

`ifdef DISPATCH_BYPASS_EN
        // Empty-buffer bypass: issues in the push cycle, nothing stored.
        expectIssue(3'b101, 1'b1);
        applyStimulus(1'b1, 3'b101, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0);
        tick();
        idle();
        checkOutput("t7_bypass_count", 32'(bus.count), 32'd0);
`endif

        tick();
        tick();
        checkOutput("issue_queue_drained", 32'(expQ.size()), 32'd0);
        checkOutput("redirect_queue_drained", 32'(redQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
